dsi_packet_streamer: RTL and testbench
======================================

// Module: dsi_packet_streamer
// PURPOSE
//  Producer side of the lanes-controller word interface (iface_write_* / iface_data_rqst).
//  Builds one DSI packet per command and streams it as 32-bit little-endian words:
//  header DI|WC/data|ECC, then the long-packet payload from an upstream word stream,
//  then the CRC16 footer. Sits between the command/pixel engines and dsi_lanes_controller.
// PARAMETERS
//  ECC_ENABLE  1  1: header byte3 = computed ECC; 0: header byte3 = 8'h00
//  CRC_ENABLE  1  1: footer = CRC16 of payload; 0: footer = 16'h0000
// PORTS
//  clk_sys            in   1   system clock; all logic on its rising edge
//  rst                in   1   synchronous reset, active-high
//  pkt_start          in   1   command strobe; accepted only when pkt_ready=1
//  pkt_ready          out  1   1 in IDLE only
//  pkt_long           in   1   1 = long packet (payload+CRC), 0 = short packet
//  pkt_vc             in   2   virtual channel, DI[7:6]
//  pkt_data_type      in   6   data type, DI[5:0]
//  pkt_word_count     in   16  long: payload byte count WC; short: {data1,data0}
//  pld_data           in   32  payload word, byte0 = bits[7:0] = first byte on the wire
//  pld_valid          in   1   payload word available
//  pld_ready          out 1   payload word consumed at this edge when pld_valid=1
//  iface_write_data   out  32  word to lanes controller
//  iface_write_strb   out  4   valid-byte mask, always contiguous from bit0
//  iface_write_rqst   out  1   word presented
//  iface_last_word    out  1   presented word is the packet's last
//  iface_data_rqst    in   1   lanes controller accepts presented word
//  pkt_busy           out  1   packet in progress (not IDLE)
//  pkt_done           out  1   one-cycle pulse, cycle after last word accepted
// BEHAVIOUR
//  Reset: state IDLE; pkt_ready=1; pld_ready, iface_write_rqst, iface_last_word,
//   pkt_busy, pkt_done=0; iface_write_data=0; iface_write_strb=0; CRC reg=16'hFFFF.
//  Transfer: word moves when iface_write_rqst && iface_data_rqst at a clk_sys edge.
//   While rqst=1 and not accepted, data/strb/last stay frozen. Next word may be presented
//   the cycle after acceptance (1 word/cycle max). rqst never drops without a transfer.
//  Command: pkt_start && pkt_ready at edge N latches the fields; header presented at N+1.
//   pkt_start while busy is ignored (no queueing).
//  Header word: byte0=DI={vc,dt}, byte1=WC[7:0], byte2=WC[15:8], byte3=ECC(bytes0..2),
//   MIPI DSI 6-bit Hamming ECC, bits[7:6]=0; strb=4'hF.
//  FSM: IDLE -> HDR (start) -> short: DONE on header accept, last_word=1 with header.
//   long: HDR -> PLD (WC>=1) or TAIL (WC=0) on header accept; PLD -> TAIL/DONE; TAIL -> DONE;
//   DONE: pkt_done=1 one cycle -> IDLE (pkt_ready=1 again in the following cycle).
//  PLD: pld_ready=1 only when output slot empty or being accepted this edge; payload words
//   = ceil(WC/4); byte counter decrements by 4, saturating. pld_valid=0 -> rqst low (bubble);
//   no error is raised here (lanes controller flags underflow).
//  CRC: CCITT poly x^16+x^12+x^5+1, reflected (LSB first), init 16'hFFFF, no final XOR;
//   updated over valid payload bytes only; computed combinationally over the last
//   payload word so footer bytes merge into it. Footer order: CRC[7:0] then CRC[15:8].
//  Footer packing, r = WC mod 4, last payload word bytes 0..r-1 valid:
//   r=1: bytes1,2=CRC, strb 4'h7, last.  r=2: bytes2,3=CRC, strb 4'hF, last.
//   r=3: byte3=CRC lo, strb 4'hF; then TAIL word byte0=CRC hi, strb 4'h1, last.
//   r=0 (incl. WC=0): TAIL word bytes0,1=CRC, strb 4'h3, last.
//  Unused bytes of a partial word are 8'h00. Excess pld bits beyond WC are ignored.
//  WC=16'hFFFF handled without overflow (17-bit internal count allowed).
//  Reset mid-packet: immediate return to IDLE next edge, outputs to reset values; consumed
//   payload words are not replayed; partially sent packet is abandoned.
// TESTING
//  Short pkt vc=0 dt=6'h05 wc=16'h0029 -> one word {ECC,00,29,05} strb F last=1, pkt_done next.
//  Long WC=0 dt=6'h39 -> header strb F last=0, then {0000,FFFF} strb 3 last=1; pld_ready never 1.
//  Long WC=6, bytes 01..06 -> hdr, {04030201} strb F, {CRChi,CRClo,06,05} strb F last;
//   CRC matches bench model.
//  Long WC=7 with iface_data_rqst toggling random 50% -> 4 words, 4th strb 1 = CRC hi;
//   data frozen while stalled.
//  pld_valid gaps of 3 cycles mid-payload -> rqst low during gaps, byte stream intact;
//   pkt_start during busy ignored.
//  rst asserted during PLD of WC=64 -> next cycle rqst=0, pkt_ready=1; new short packet ok.

Source files
------------

// File: rtl/dsi_packet_streamer.sv
// Builds one DSI packet per command (header, long payload, CRC16 footer) and streams it
// as 32-bit little-endian words to the lanes controller.
//  state  | meaning
//  S_IDLE | waiting for pkt_start
//  S_HDR  | header word presented
//  S_PLD  | payload words streaming; short CRC tails merge into the last word
//  S_TAIL | separate footer word pending or presented
//  S_DONE | one-cycle pkt_done pulse
module dsi_packet_streamer #(
  parameter bit ECC_ENABLE = 1'b1,
  parameter bit CRC_ENABLE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pkt_start,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [1:0]  pkt_vc,
  input  logic [5:0]  pkt_data_type,
  input  logic [15:0] pkt_word_count,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  input  logic        iface_data_rqst,
  output logic        pkt_busy,
  output logic        pkt_done
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_TAIL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        long_q;
  logic [16:0] rem_q;
  logic [15:0] crc_q;
  logic        tail_hi_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        last_q;
  logic        rqst_q;

  logic        accept, slot_free, start_ok, pld_take, pld_final, load_tail;
  logic [31:0] pld_masked;
  logic [15:0] crc_next, crc_foot, crc_tail;
  logic [31:0] tail_word;
  logic [5:0]  hdr_ecc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // MIPI DSI Hamming parity masks over the 24 header bits
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] e;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return e;
  endfunction

  assign accept    = rqst_q && iface_data_rqst;
  assign slot_free = !rqst_q || iface_data_rqst;
  assign start_ok  = pkt_start && (state_q == S_IDLE);
  assign pld_ready = (state_q == S_PLD) && (rem_q != 17'd0) && slot_free;
  assign pld_take  = pld_valid && pld_ready;
  assign pld_final = (rem_q <= 17'd4);
  assign hdr_ecc   = ECC_ENABLE ? calc_ecc({pkt_word_count, pkt_vc, pkt_data_type}) : 6'h00;
  assign crc_foot  = CRC_ENABLE ? crc_next : 16'h0000;
  assign crc_tail  = CRC_ENABLE ? crc_q : 16'h0000;
  assign tail_word = tail_hi_q ? {24'h000000, crc_tail[15:8]} : {16'h0000, crc_tail};
  assign load_tail = ((state_q == S_HDR) && accept && long_q && (rem_q == 17'd0)) ||
                     ((state_q == S_TAIL) && slot_free && !(rqst_q && last_q));

  always_comb begin
    pld_masked = '0;
    crc_next   = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (rem_q > 17'(i)) begin
        pld_masked[8*i +: 8] = pld_data[8*i +: 8];
        crc_next = crc_byte(crc_next, pld_data[8*i +: 8]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_HDR;
      S_HDR: begin
        if (accept) begin
          if (!long_q)               state_d = S_DONE;
          else if (rem_q == 17'd0)   state_d = S_TAIL;
          else                       state_d = S_PLD;
        end
      end
      S_PLD: begin
        if (accept && last_q) state_d = S_DONE;
        else if (pld_take && (rem_q == 17'd3 || rem_q == 17'd4)) state_d = S_TAIL;
      end
      S_TAIL: if (accept && last_q) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      long_q    <= 1'b0;
      rem_q     <= '0;
      crc_q     <= 16'hFFFF;
      tail_hi_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
      last_q    <= 1'b0;
      rqst_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        long_q    <= pkt_long;
        rem_q     <= {1'b0, pkt_word_count};
        crc_q     <= 16'hFFFF;
        tail_hi_q <= 1'b0;
        data_q    <= {2'b00, hdr_ecc, pkt_word_count, pkt_vc, pkt_data_type};
        strb_q    <= 4'hF;
        last_q    <= !pkt_long;
        rqst_q    <= 1'b1;
      end else if (pld_take) begin
        rqst_q <= 1'b1;
        strb_q <= 4'hF;
        last_q <= 1'b0;
        data_q <= pld_masked;
        crc_q  <= crc_next;
        if (pld_final) begin
          rem_q <= '0;
          // footer bytes merge into whatever room the last payload word leaves
          case (rem_q[2:0])
            3'd1: begin
              data_q <= {8'h00, crc_foot, pld_masked[7:0]};
              strb_q <= 4'h7;
              last_q <= 1'b1;
            end
            3'd2: begin
              data_q <= {crc_foot, pld_masked[15:0]};
              last_q <= 1'b1;
            end
            3'd3: begin
              data_q    <= {crc_foot[7:0], pld_masked[23:0]};
              tail_hi_q <= 1'b1;
            end
            default: tail_hi_q <= 1'b0;
          endcase
        end else begin
          rem_q <= rem_q - 17'd4;
        end
      end else if (load_tail) begin
        data_q <= tail_word;
        strb_q <= tail_hi_q ? 4'h1 : 4'h3;
        last_q <= 1'b1;
        rqst_q <= 1'b1;
      end else if (accept) begin
        rqst_q <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  assign iface_write_data = data_q;
  assign iface_write_strb = strb_q;
  assign iface_write_rqst = rqst_q;
  assign iface_last_word  = last_q;
  assign pkt_ready        = (state_q == S_IDLE);
  assign pkt_busy         = (state_q != S_IDLE);
  assign pkt_done         = (state_q == S_DONE);

endmodule

// File: tb/tb_dsi_packet_streamer.sv
// Directed bench for dsi_packet_streamer: short/long packets, footer packing, stalls,
// payload gaps and mid-packet reset against hand-computed words.
module tb_dsi_packet_streamer;

  logic        clk_sys;
  logic        rst;
  logic        pkt_start;
  logic        pkt_ready;
  logic        pkt_long;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_data_type;
  logic [15:0] pkt_word_count;
  logic [31:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst;
  logic        iface_last_word;
  logic        iface_data_rqst;
  logic        pkt_busy;
  logic        pkt_done;

  int checks = 0;
  int failures = 0;

  logic [31:0] cap_data[$];
  logic [3:0]  cap_strb[$];
  logic        cap_last[$];
  logic [31:0] pld_mem[32];
  bit          pld_ready_seen;

  dsi_packet_streamer dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .pkt_start        (pkt_start),
    .pkt_ready        (pkt_ready),
    .pkt_long         (pkt_long),
    .pkt_vc           (pkt_vc),
    .pkt_data_type    (pkt_data_type),
    .pkt_word_count   (pkt_word_count),
    .pld_data         (pld_data),
    .pld_valid        (pld_valid),
    .pld_ready        (pld_ready),
    .iface_write_data (iface_write_data),
    .iface_write_strb (iface_write_strb),
    .iface_write_rqst (iface_write_rqst),
    .iface_last_word  (iface_last_word),
    .iface_data_rqst  (iface_data_rqst),
    .pkt_busy         (pkt_busy),
    .pkt_done         (pkt_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // bit-serial reflected CCITT, one bit at a time
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic run_pkt(input string tag, input logic lng, input logic [1:0] vc,
                         input logic [5:0] dt, input logic [15:0] wc,
                         input bit stall, input bit gaps);
    int pidx, nwords, gap_cnt;
    bit hold, finished, gap_now, acc, take;
    logic [31:0] hd;
    logic [3:0]  hs;
    logic        hl;
    cap_data.delete();
    cap_strb.delete();
    cap_last.delete();
    pld_ready_seen = 1'b0;
    nwords = lng ? (int'(wc) + 3) / 4 : 0;
    pidx = 0; gap_cnt = 0; hold = 1'b0; finished = 1'b0;
    hd = '0; hs = '0; hl = 1'b0;
    @(negedge clk_sys);
    pkt_long = lng; pkt_vc = vc; pkt_data_type = dt; pkt_word_count = wc;
    pkt_start = 1'b1;
    @(posedge clk_sys);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk_sys);
      iface_data_rqst = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      gap_now   = gaps && (pidx == 2) && (gap_cnt < 3);
      pld_valid = (pidx < nwords) && !gap_now;
      pld_data  = (pidx < nwords) ? pld_mem[pidx] : 32'h0;
      pkt_start = gap_now && (gap_cnt == 1);
      if (pkt_start) begin
        pkt_long = 1'b0; pkt_data_type = 6'h3F;
      end
      #1;
      if (pld_ready === 1'b1) pld_ready_seen = 1'b1;
      if (hold) begin
        checks++;
        if ({iface_write_rqst, iface_write_data, iface_write_strb, iface_last_word} !==
            {1'b1, hd, hs, hl}) begin
          failures++;
          $display("FAIL %s_frozen got rqst=%b data=%h strb=%h last=%b exp rqst=1 data=%h strb=%h last=%b",
                   tag, iface_write_rqst, iface_write_data, iface_write_strb, iface_last_word, hd, hs, hl);
        end
      end
      if (gap_now && gap_cnt >= 1) begin
        checks++;
        if (iface_write_rqst !== 1'b0) begin
          failures++;
          $display("FAIL %s_gap_rqst got=%b exp=0", tag, iface_write_rqst);
        end
      end
      acc  = iface_write_rqst && iface_data_rqst;
      take = pld_valid && pld_ready;
      hold = iface_write_rqst && !iface_data_rqst;
      hd = iface_write_data; hs = iface_write_strb; hl = iface_last_word;
      if (acc) begin
        cap_data.push_back(iface_write_data);
        cap_strb.push_back(iface_write_strb);
        cap_last.push_back(iface_last_word);
        if (iface_last_word) finished = 1'b1;
      end
      if (take) pidx++;
      if (gap_now) gap_cnt++;
      @(posedge clk_sys);
    end
    pkt_start = 1'b0; pld_valid = 1'b0; iface_data_rqst = 1'b1;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s_timeout got=no_last_word exp=last_word_within_400_cycles", tag);
    end else begin
      @(negedge clk_sys);
      if ({pkt_done, pkt_ready, iface_write_rqst} !== 3'b100) begin
        failures++;
        $display("FAIL %s_done_pulse got done/ready/rqst=%b%b%b exp=100", tag, pkt_done, pkt_ready, iface_write_rqst);
      end
      @(negedge clk_sys);
      checks++;
      if ({pkt_done, pkt_ready, pkt_busy} !== 3'b010) begin
        failures++;
        $display("FAIL %s_back_idle got done/ready/busy=%b%b%b exp=010", tag, pkt_done, pkt_ready, pkt_busy);
      end
      checks++;
      if (pidx != nwords) begin
        failures++;
        $display("FAIL %s_pld_consumed got=%0d exp=%0d", tag, pidx, nwords);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({pkt_ready, pkt_busy, pkt_done, pld_ready, iface_write_rqst, iface_last_word} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got ready/busy/done/pld_ready/rqst/last=%b%b%b%b%b%b exp=100000",
               pkt_ready, pkt_busy, pkt_done, pld_ready, iface_write_rqst, iface_last_word);
    end
    checks++;
    if ({iface_write_data, iface_write_strb} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data got data=%h strb=%h exp data=0 strb=0", iface_write_data, iface_write_strb);
    end
    rst = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({pkt_ready, iface_write_rqst} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got ready/rqst=%b%b exp=10", pkt_ready, iface_write_rqst);
    end
  endtask

  task automatic test_short;
    run_pkt("short1", 1'b0, 2'd0, 6'h05, 16'h0029, 1'b0, 1'b0);
    checks++;
    if (cap_data.size() != 1) begin
      failures++;
      $display("FAIL short1_words got=%0d exp=1", cap_data.size());
    end else begin
      checks++;
      if ({cap_data[0], cap_strb[0], cap_last[0]} !== {32'h1C002905, 4'hF, 1'b1}) begin
        failures++;
        $display("FAIL short1_word got=%h/%h/%b exp=1c002905/f/1", cap_data[0], cap_strb[0], cap_last[0]);
      end
    end
  endtask

  task automatic test_long_wc0;
    run_pkt("wc0", 1'b1, 2'd0, 6'h39, 16'd0, 1'b0, 1'b0);
    checks++;
    if (pld_ready_seen) begin
      failures++;
      $display("FAIL wc0_pld_ready got=1 exp=never");
    end
    checks++;
    if (cap_data.size() != 2) begin
      failures++;
      $display("FAIL wc0_words got=%0d exp=2", cap_data.size());
    end else begin
      checks++;
      if ({cap_data[0], cap_strb[0], cap_last[0]} !== {32'h0F000039, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL wc0_hdr got=%h/%h/%b exp=0f000039/f/0", cap_data[0], cap_strb[0], cap_last[0]);
      end
      checks++;
      if ({cap_data[1], cap_strb[1], cap_last[1]} !== {32'h0000FFFF, 4'h3, 1'b1}) begin
        failures++;
        $display("FAIL wc0_tail got=%h/%h/%b exp=0000ffff/3/1", cap_data[1], cap_strb[1], cap_last[1]);
      end
    end
  endtask

  task automatic test_long_wc6;
    logic [15:0] c;
    logic [31:0] ed[3];
    logic [3:0]  es[3];
    logic        el[3];
    c = 16'hFFFF;
    for (int i = 1; i <= 6; i++) c = crc_upd(c, 8'(i));
    pld_mem[0] = 32'h04030201;
    pld_mem[1] = 32'hEEFF0605;
    ed[0] = 32'h23000629; es[0] = 4'hF; el[0] = 1'b0;
    ed[1] = 32'h04030201; es[1] = 4'hF; el[1] = 1'b0;
    ed[2] = {c[15:8], c[7:0], 16'h0605}; es[2] = 4'hF; el[2] = 1'b1;
    run_pkt("wc6", 1'b1, 2'd0, 6'h29, 16'd6, 1'b0, 1'b0);
    checks++;
    if (cap_data.size() != 3) begin
      failures++;
      $display("FAIL wc6_words got=%0d exp=3", cap_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({cap_data[i], cap_strb[i], cap_last[i]} !== {ed[i], es[i], el[i]}) begin
          failures++;
          $display("FAIL wc6_word%0d got=%h/%h/%b exp=%h/%h/%b", i, cap_data[i], cap_strb[i], cap_last[i], ed[i], es[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_long_wc9;
    logic [31:0] ed[4];
    logic [3:0]  es[4];
    logic        el[4];
    pld_mem[0] = 32'h34333231;
    pld_mem[1] = 32'h38373635;
    pld_mem[2] = 32'hDEAD0039;
    // CRC of ASCII "123456789" with this polynomial/init is 16'h6F91
    ed[0] = 32'h23000929; es[0] = 4'hF; el[0] = 1'b0;
    ed[1] = 32'h34333231; es[1] = 4'hF; el[1] = 1'b0;
    ed[2] = 32'h38373635; es[2] = 4'hF; el[2] = 1'b0;
    ed[3] = 32'h006F9139; es[3] = 4'h7; el[3] = 1'b1;
    run_pkt("wc9", 1'b1, 2'd0, 6'h29, 16'd9, 1'b0, 1'b0);
    checks++;
    if (cap_data.size() != 4) begin
      failures++;
      $display("FAIL wc9_words got=%0d exp=4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({cap_data[i], cap_strb[i], cap_last[i]} !== {ed[i], es[i], el[i]}) begin
          failures++;
          $display("FAIL wc9_word%0d got=%h/%h/%b exp=%h/%h/%b", i, cap_data[i], cap_strb[i], cap_last[i], ed[i], es[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_stall_wc7;
    logic [15:0] c;
    logic [7:0]  b[7];
    logic [31:0] ed[4];
    logic [3:0]  es[4];
    logic        el[4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    b[4] = 8'h55; b[5] = 8'h66; b[6] = 8'h77;
    c = 16'hFFFF;
    for (int i = 0; i < 7; i++) c = crc_upd(c, b[i]);
    pld_mem[0] = 32'h44332211;
    pld_mem[1] = 32'hAB776655;
    ed[0] = 32'h39000729; es[0] = 4'hF; el[0] = 1'b0;
    ed[1] = 32'h44332211; es[1] = 4'hF; el[1] = 1'b0;
    ed[2] = {c[7:0], 24'h776655}; es[2] = 4'hF; el[2] = 1'b0;
    ed[3] = {24'h0, c[15:8]}; es[3] = 4'h1; el[3] = 1'b1;
    run_pkt("wc7_stall", 1'b1, 2'd0, 6'h29, 16'd7, 1'b1, 1'b0);
    checks++;
    if (cap_data.size() != 4) begin
      failures++;
      $display("FAIL wc7_words got=%0d exp=4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({cap_data[i], cap_strb[i], cap_last[i]} !== {ed[i], es[i], el[i]}) begin
          failures++;
          $display("FAIL wc7_word%0d got=%h/%h/%b exp=%h/%h/%b", i, cap_data[i], cap_strb[i], cap_last[i], ed[i], es[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_gaps_busy_start;
    logic [15:0] c;
    logic [31:0] ed[5];
    logic [3:0]  es[5];
    logic        el[5];
    c = 16'hFFFF;
    for (int i = 0; i < 12; i++) c = crc_upd(c, 8'hA0 + 8'(i));
    pld_mem[0] = 32'hA3A2A1A0;
    pld_mem[1] = 32'hA7A6A5A4;
    pld_mem[2] = 32'hABAAA9A8;
    ed[0] = 32'h1A000C29; es[0] = 4'hF; el[0] = 1'b0;
    ed[1] = 32'hA3A2A1A0; es[1] = 4'hF; el[1] = 1'b0;
    ed[2] = 32'hA7A6A5A4; es[2] = 4'hF; el[2] = 1'b0;
    ed[3] = 32'hABAAA9A8; es[3] = 4'hF; el[3] = 1'b0;
    ed[4] = {16'h0000, c}; es[4] = 4'h3; el[4] = 1'b1;
    run_pkt("wc12_gaps", 1'b1, 2'd0, 6'h29, 16'd12, 1'b0, 1'b1);
    checks++;
    if (cap_data.size() != 5) begin
      failures++;
      $display("FAIL wc12_words got=%0d exp=5", cap_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({cap_data[i], cap_strb[i], cap_last[i]} !== {ed[i], es[i], el[i]}) begin
          failures++;
          $display("FAIL wc12_word%0d got=%h/%h/%b exp=%h/%h/%b", i, cap_data[i], cap_strb[i], cap_last[i], ed[i], es[i], el[i]);
        end
      end
    end
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({pkt_busy, iface_write_rqst} !== 2'b00) begin
      failures++;
      $display("FAIL busy_start_ignored got busy/rqst=%b%b exp=00", pkt_busy, iface_write_rqst);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_sys);
    pkt_long = 1'b1; pkt_vc = 2'd0; pkt_data_type = 6'h29; pkt_word_count = 16'd64;
    pkt_start = 1'b1; pld_valid = 1'b1; pld_data = 32'h5A5A5A5A; iface_data_rqst = 1'b1;
    @(posedge clk_sys);
    #1 pkt_start = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({pkt_busy, iface_write_rqst} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_streaming got busy/rqst=%b%b exp=11", pkt_busy, iface_write_rqst);
    end
    rst = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({iface_write_rqst, pkt_ready, pkt_busy, pld_ready, iface_last_word, pkt_done} !== 6'b010000) begin
      failures++;
      $display("FAIL rstmid_ctrl got rqst/ready/busy/pld_ready/last/done=%b%b%b%b%b%b exp=010000",
               iface_write_rqst, pkt_ready, pkt_busy, pld_ready, iface_last_word, pkt_done);
    end
    checks++;
    if ({iface_write_data, iface_write_strb} !== 36'h0) begin
      failures++;
      $display("FAIL rstmid_data got data=%h strb=%h exp data=0 strb=0", iface_write_data, iface_write_strb);
    end
    rst = 1'b0; pld_valid = 1'b0;
    run_pkt("short2", 1'b0, 2'd2, 6'h15, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (cap_data.size() != 1) begin
      failures++;
      $display("FAIL short2_words got=%0d exp=1", cap_data.size());
    end else begin
      checks++;
      if ({cap_data[0], cap_strb[0], cap_last[0]} !== {32'h01123495, 4'hF, 1'b1}) begin
        failures++;
        $display("FAIL short2_word got=%h/%h/%b exp=01123495/f/1", cap_data[0], cap_strb[0], cap_last[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pkt_start = 1'b0; pkt_long = 1'b0; pkt_vc = 2'd0; pkt_data_type = 6'h00;
    pkt_word_count = 16'h0; pld_data = 32'h0; pld_valid = 1'b0; iface_data_rqst = 1'b1;
    for (int i = 0; i < 32; i++) pld_mem[i] = 32'h0;
    test_reset;
    test_short;
    test_long_wc0;
    test_long_wc6;
    test_long_wc9;
    test_stall_wc7;
    test_gaps_busy_start;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
